// File: rtl/unidade_controle_rodadas_if.sv
// unidade_controle_rodadas_if: game-control bus between the bench/datapath side and the round controller
interface unidade_controle_rodadas_if #(parameter int W = 4);
    logic         iniciar;
    logic         modo;
    logic         jogada;
    logic         igual;
    logic [W-1:0] endereco;
    logic [W-1:0] rodada;
    logic         zeraR;
    logic         registraR;
    logic         pronto;
    logic         acertou;
    logic         errou;
    logic         timeout;
    logic [3:0]   db_estado;
    modport master (
        output iniciar, modo, jogada, igual,
        input  endereco, rodada, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
    );
    modport slave (
        input  iniciar, modo, jogada, igual,
        output endereco, rodada, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas: Moore controller for the memory-sequence game with progressive rounds and per-play timeout
module unidade_controle_rodadas #(
    parameter int N_JOGADAS      = 16,
    parameter int TIMEOUT_CICLOS = 3000
) (
    input logic                        clock,
    input logic                        reset_n,
    unidade_controle_rodadas_if.slave  bus
);
    localparam int W  = $clog2(N_JOGADAS);
    localparam int TW = (TIMEOUT_CICLOS == 0) ? 1 : $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [W-1:0]  ULTIMA = W'(N_JOGADAS - 1);
    localparam logic [TW-1:0] LIMITE = TW'((TIMEOUT_CICLOS == 0) ? 0 : TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        s_inicial        = 4'h0,
        s_preparacao     = 4'h1,
        s_espera         = 4'h2,
        s_registra       = 4'h4,
        s_comparacao     = 4'h5,
        s_proxima_jogada = 4'h6,
        s_proxima_rodada = 4'h7,
        s_estouro        = 4'hC,
        s_vitoria        = 4'hD,
        s_derrota        = 4'hE
    } estado_t;

    estado_t       r_estado;
    logic [W-1:0]  r_endereco;
    logic [W-1:0]  r_rodada;
    logic [TW-1:0] r_timer;
    logic          w_expirou;
    logic          w_legal;

    // a zero timeout disables expiry entirely; the timer then just free-runs unused
    assign w_expirou = (TIMEOUT_CICLOS != 0) && (r_timer == LIMITE);
    assign w_legal   = r_estado inside {s_inicial, s_preparacao, s_espera, s_registra, s_comparacao,
                                        s_proxima_jogada, s_proxima_rodada, s_estouro, s_vitoria, s_derrota};

    // Moore outputs decoded from the state register and the registered counters only
    assign bus.endereco  = r_endereco;
    assign bus.rodada    = r_rodada;
    assign bus.zeraR     = (r_estado == s_inicial) || (r_estado == s_preparacao);
    assign bus.registraR = r_estado == s_registra;
    assign bus.pronto    = r_estado inside {s_vitoria, s_derrota, s_estouro};
    assign bus.acertou   = r_estado == s_vitoria;
    assign bus.errou     = r_estado inside {s_derrota, s_estouro};
    assign bus.timeout   = r_estado == s_estouro;
    assign bus.db_estado = w_legal ? 4'(r_estado) : 4'hF;

    // state and counter updates; state codes double as the debug display codes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado   <= s_inicial;
            r_endereco <= '0;
            r_rodada   <= '0;
            r_timer    <= '0;
        end else begin
            case (r_estado)
                s_inicial: if (bus.iniciar) r_estado <= s_preparacao;
                s_preparacao: begin
                    r_endereco <= '0;
                    r_timer    <= '0;
                    r_rodada   <= bus.modo ? '0 : ULTIMA;
                    r_estado   <= s_espera;
                end
                s_espera: begin
                    if (bus.jogada) r_estado <= s_registra;
                    else if (w_expirou) r_estado <= s_estouro;
                    else r_timer <= r_timer + TW'(1);
                end
                s_registra: r_estado <= s_comparacao;
                s_comparacao: begin
                    if (!bus.igual) r_estado <= s_derrota;
                    else if (r_endereco == r_rodada) r_estado <= (r_rodada == ULTIMA) ? s_vitoria : s_proxima_rodada;
                    else r_estado <= s_proxima_jogada;
                end
                s_proxima_jogada: begin
                    r_endereco <= r_endereco + W'(1);
                    r_timer    <= '0;
                    r_estado   <= s_espera;
                end
                s_proxima_rodada: begin
                    r_rodada   <= r_rodada + W'(1);
                    r_endereco <= '0;
                    r_timer    <= '0;
                    r_estado   <= s_espera;
                end
                s_vitoria, s_derrota, s_estouro: if (bus.iniciar) r_estado <= s_preparacao;
                default: r_estado <= s_inicial;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// tb_unidade_controle_rodadas: scoreboard bench for the round controller (timeout 8 and timeout disabled)
module tb_unidade_controle_rodadas;
    typedef struct {
        int e;
        int r;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_reg    = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    unidade_controle_rodadas_if #(.W(2)) bus ();
    unidade_controle_rodadas_if #(.W(2)) bus0 ();

    unidade_controle_rodadas #(.N_JOGADAS(4), .TIMEOUT_CICLOS(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    unidade_controle_rodadas #(.N_JOGADAS(4), .TIMEOUT_CICLOS(0)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // every registraR cycle consumes one expected (endereco, rodada) pair
    always @(negedge clock) begin
        if (reset_n && bus.registraR) begin
            exp_t x;
            n_reg++;
            if (sb.size() == 0) check("reg_unexpected", 1, 0);
            else begin
                x = sb.pop_front();
                check("reg_endereco", int'(bus.endereco), x.e);
                check("reg_rodada", int'(bus.rodada), x.r);
            end
        end
    end

    task automatic start(input bit m);
        bus.modo    = m;
        bus.iniciar = 1'b1;
        tick;
        check("preparacao", int'(bus.db_estado), 1);
        check("prep_zeraR", int'(bus.zeraR), 1);
        bus.iniciar = 1'b0;
        tick;
        check("espera", int'(bus.db_estado), 2);
        check("start_endereco", int'(bus.endereco), 0);
        check("start_rodada", int'(bus.rodada), m ? 0 : 3);
    endtask

    task automatic play(input bit ig, input int e, input int r);
        sb.push_back('{e: e, r: r});
        bus.igual  = ig;
        bus.jogada = 1'b1;
        tick;
        bus.jogada = 1'b0;
        check("registra", int'(bus.db_estado), 4);
        tick;
        check("comparacao", int'(bus.db_estado), 5);
        check("reg_one_cycle", int'(bus.registraR), 0);
        tick;
        bus.igual = 1'b1;
    endtask

    task automatic check_reset;
        check("rst_db", int'(bus.db_estado), 0);
        check("rst_zeraR", int'(bus.zeraR), 1);
        check("rst_endereco", int'(bus.endereco), 0);
        check("rst_rodada", int'(bus.rodada), 0);
        check("rst_registraR", int'(bus.registraR), 0);
        check("rst_pronto", int'(bus.pronto), 0);
        check("rst_acertou", int'(bus.acertou), 0);
        check("rst_errou", int'(bus.errou), 0);
        check("rst_timeout", int'(bus.timeout), 0);
    endtask

    initial begin
        bus.iniciar  = 1'b0;
        bus.modo     = 1'b0;
        bus.jogada   = 1'b0;
        bus.igual    = 1'b1;
        bus0.iniciar = 1'b0;
        bus0.modo    = 1'b0;
        bus0.jogada  = 1'b0;
        bus0.igual   = 1'b1;
        #2;
        check_reset;
        @(negedge clock);
        reset_n = 1'b1;
        tick;
        check("idle_inicial", int'(bus.db_estado), 0);

        // classic mode: four plays, rodada fixed at 3
        n_reg = 0;
        start(1'b0);
        for (int i = 0; i < 4; i++) begin
            play(1'b1, i, 3);
            if (i < 3) begin
                check("m0_proxima_jogada", int'(bus.db_estado), 6);
                check("m0_pronto_early", int'(bus.pronto), 0);
                tick;
                check("m0_espera", int'(bus.db_estado), 2);
                check("m0_endereco", int'(bus.endereco), i + 1);
                check("m0_rodada", int'(bus.rodada), 3);
            end
        end
        check("m0_vitoria", int'(bus.db_estado), 13);
        check("m0_pronto", int'(bus.pronto), 1);
        check("m0_acertou", int'(bus.acertou), 1);
        check("m0_errou", int'(bus.errou), 0);
        check("m0_reg_pulses", n_reg, 4);
        repeat (3) tick;
        check("m0_vitoria_hold", int'(bus.db_estado), 13);

        // progressive mode from vitoria: 1+2+3+4 plays
        start(1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e <= r; e++) begin
                play(1'b1, e, r);
                if (e < r) begin
                    check("m1_proxima_jogada", int'(bus.db_estado), 6);
                    check("m1_pronto_early", int'(bus.pronto), 0);
                    tick;
                    check("m1_endereco", int'(bus.endereco), e + 1);
                end else if (r < 3) begin
                    check("m1_proxima_rodada", int'(bus.db_estado), 7);
                    check("m1_pronto_early", int'(bus.pronto), 0);
                    tick;
                    check("m1_rodada", int'(bus.rodada), r + 1);
                    check("m1_endereco_zero", int'(bus.endereco), 0);
                    check("m1_espera", int'(bus.db_estado), 2);
                end
            end
        end
        check("m1_vitoria", int'(bus.db_estado), 13);
        check("m1_acertou", int'(bus.acertou), 1);

        // progressive mode, wrong second play of round 1
        start(1'b1);
        play(1'b1, 0, 0);
        check("m1f_proxima_rodada", int'(bus.db_estado), 7);
        tick;
        play(1'b1, 0, 1);
        check("m1f_proxima_jogada", int'(bus.db_estado), 6);
        tick;
        play(1'b0, 1, 1);
        check("derrota", int'(bus.db_estado), 14);
        check("derrota_pronto", int'(bus.pronto), 1);
        check("derrota_errou", int'(bus.errou), 1);
        check("derrota_acertou", int'(bus.acertou), 0);
        check("derrota_timeout", int'(bus.timeout), 0);
        check("derrota_endereco", int'(bus.endereco), 1);
        check("derrota_rodada", int'(bus.rodada), 1);

        // timeout after 8 idle espera cycles
        start(1'b0);
        repeat (7) tick;
        check("to_still_espera", int'(bus.db_estado), 2);
        tick;
        check("estouro", int'(bus.db_estado), 12);
        check("estouro_pronto", int'(bus.pronto), 1);
        check("estouro_errou", int'(bus.errou), 1);
        check("estouro_timeout", int'(bus.timeout), 1);

        // jogada in the 8th cycle beats expiry
        start(1'b0);
        repeat (7) tick;
        play(1'b1, 0, 3);
        check("to_jogada_wins", int'(bus.db_estado), 6);
        check("to_no_timeout", int'(bus.timeout), 0);
        tick;
        check("to_back_espera", int'(bus.db_estado), 2);

        // asynchronous reset in the middle of espera
        repeat (3) tick;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset;
        @(negedge clock);
        reset_n = 1'b1;
        tick;
        check("post_rst_inicial", int'(bus.db_estado), 0);

        // timeout disabled: espera holds indefinitely
        bus0.iniciar = 1'b1;
        tick;
        bus0.iniciar = 1'b0;
        tick;
        check("t0_espera", int'(bus0.db_estado), 2);
        repeat (100) tick;
        check("t0_still_espera", int'(bus0.db_estado), 2);
        check("t0_timeout", int'(bus0.timeout), 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/unidade_controle_rodadas.md
# unidade_controle_rodadas

Parametrised control unit for the memory-sequence game: next generation of the fixed-length play controller. It owns the play-address and round counters, supports a progressive-round mode (round k requires k+1 correct plays) alongside the classic full-sequence mode, and aborts a game on a per-play timeout. It sits between the button-edge detector and the datapath (sequence memory, play register, comparator) and drives the memory address, register controls and game-status outputs.

## Interface
- N_JOGADAS, 16: maximum sequence length, ≥2.
- TIMEOUT_CICLOS, 3000: clock cycles allowed in espera per play; 0 disables the timeout.
- W, $clog2(N_JOGADAS): width of the address and round counters, derived and not overridden.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iniciar  in  1  start or restart game, level-sampled.
- modo  in  1  0 = full sequence each game; 1 = progressive rounds. Sampled only in preparacao.
- jogada  in  1  one-cycle pulse: a play button was pressed.
- igual  in  1  comparator result: stored play equals memory word at endereco.
- endereco  out  W  sequence-memory address (current play index).
- rodada  out  W  current round limit (last index of this round).
- zeraR  out  1  clear play register.
- registraR  out  1  load play register.
- pronto  out  1  game ended (vitoria, derrota or estouro).
- acertou  out  1  game won.
- errou  out  1  game lost (wrong play or timeout).
- timeout  out  1  game lost by timeout.
- db_estado  out  4  state code for the 7-segment debug display.

## Operation
- Moore FSM; every output is a function of state and registered counters only.
- States and db_estado codes:
  - inicial 0
  - preparacao 1
  - espera 2
  - registra 4
  - comparacao 5
  - proxima_jogada 6
  - proxima_rodada 7
  - vitoria D
  - derrota E
  - estouro C
  - Unused codes → inicial, with db_estado=F.
- inicial: zeraR=1. iniciar → preparacao.
- preparacao: zeraR=1. Sets endereco←0 and timer←0. Sets rodada←0 if modo=1, else rodada←N_JOGADAS-1. Latches modo. Goes unconditionally to espera.
- espera:
  - jogada=1 → registra.
  - Otherwise, if TIMEOUT_CICLOS≠0 and timer=TIMEOUT_CICLOS-1 → estouro.
  - Otherwise timer←timer+1.
- registra: registraR=1 → comparacao.
- comparacao, in priority order:
  - igual=0 → derrota.
  - endereco=rodada and rodada=N_JOGADAS-1 → vitoria.
  - endereco=rodada → proxima_rodada.
  - Otherwise → proxima_jogada.
- proxima_jogada: endereco←endereco+1, timer←0 → espera.
- proxima_rodada: rodada←rodada+1, endereco←0, timer←0 → espera.
- vitoria: pronto=1, acertou=1.
- derrota: pronto=1, errou=1.
- estouro: pronto=1, errou=1, timeout=1.
- From any terminal state, iniciar → preparacao, which starts a new game directly without passing through inicial. Terminal outputs hold until then.
- Counters never wrap: endereco ≤ rodada ≤ N_JOGADAS-1 is invariant.
- The timer is an internal counter of width clog2(TIMEOUT_CICLOS+1). It is not output.
- jogada outside espera is ignored. iniciar outside inicial and the terminal states is ignored; there is no mid-game restart.

## Timing
- reset_n low, asynchronously and immediately:
  - state=inicial, endereco=0, rodada=0, timer=0.
  - zeraR=1, db_estado=0, all other outputs 0.
- Reset mid-game aborts with no terminal state shown.
- Latency: jogada sampled high in espera at edge k gives registra after k, comparacao after k+1, and the next state (espera-bound or terminal) after k+2. registraR is high for exactly one cycle.
- Next play is accepted 3 cycles after the previous jogada on the continue path (registra, comparacao, proxima_*). It is 4 cycles counting the return to espera.
- Timeout: estouro is entered on the edge ending the TIMEOUT_CICLOS-th consecutive espera cycle without jogada.
- jogada and timer expiry in the same cycle: jogada wins.
- Outputs change only on clock edges. Reset is the only exception.

## Test plan
- N_JOGADAS=4, TIMEOUT_CICLOS=8, modo=0, igual=1 throughout:
  - Stimulus: iniciar, then 4 jogada pulses.
  - Required: endereco steps 0,1,2,3; rodada=3 throughout; registraR pulses 4 times; final vitoria, pronto=1, acertou=1, db_estado=D.
- modo=1, igual=1:
  - Stimulus: 1+2+3+4 = 10 jogadas.
  - Required: rodada steps 0,1,2,3; endereco returns to 0 after each round; vitoria after the 10th play; never earlier.
- modo=1, igual=0 on the 2nd play of round 1:
  - Required: derrota, errou=1, acertou=0, timeout=0, db_estado=E, endereco=1, rodada=1.
- Timeout:
  - Stimulus: no jogada for 8 cycles in espera.
  - Required: estouro on the 8th edge, errou=1, timeout=1, db_estado=C.
  - With jogada in the 8th cycle instead: registra, no timeout.
- Restart and reset:
  - iniciar in vitoria → preparacao next edge; counters cleared.
  - reset_n low mid-espera → immediate inicial, all outputs at reset values, without waiting for a clock edge.
- TIMEOUT_CICLOS=0:
  - Stimulus: 100 idle cycles in espera.
  - Required: state stays espera.
